hssthp_refclk_ctrl: RTL

Parametrised reference-clock supervisor for up to four HSSTHP reference-clock buffers. Per channel, it sequences the buffer's common power-down, measures the recovered reference clock against the free-running fabric clock, and reports lock and loss of clock. It re-power-cycles a buffer automatically when no clock appears. It sits between the per-quad BUFDS wrappers (driving their COM_POWERDOWN) and the transceiver reset/PLL sequencer (consuming `o_refclk_ok`).

---
 rtl/hssthp_refclk_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/hssthp_refclk_ctrl.sv
// Reference-clock supervisor for up to four HSSTHP refclk buffers.
// Per channel: sequences COM_POWERDOWN, measures the toggled refclk against
// the free-running clock over a shared window, and reports lock / loss.
`timescale 1ns/1ps
module hssthp_refclk_ctrl #(
    parameter int NUM_REFCLK     = 1,
    parameter int WINDOW_CYCLES  = 1000,
    parameter int EXP_CNT        = 781,
    parameter int TOL            = 8,
    parameter int CNT_W          = 16,
    parameter int PD_HOLD_CYCLES = 256,
    parameter int GOOD_WINDOWS   = 4,
    parameter int RETRY_WINDOWS  = 16
) (
    input  logic                        i_free_clk,
    input  logic                        i_rst,
    input  logic [NUM_REFCLK-1:0]       i_refclk_tgl,
    input  logic [NUM_REFCLK-1:0]       i_pd_req,
    output logic [NUM_REFCLK-1:0]       o_com_powerdown,
    output logic [NUM_REFCLK-1:0]       o_refclk_ok,
    output logic [NUM_REFCLK-1:0]       o_refclk_lost,
    output logic [NUM_REFCLK*CNT_W-1:0] o_freq_cnt,
    output logic [NUM_REFCLK*4-1:0]     o_retry_cnt
);
    localparam int WIN_W  = $clog2(WINDOW_CYCLES);
    localparam int HOLD_W = $clog2(PD_HOLD_CYCLES + 1);
    localparam int GOOD_W = $clog2(GOOD_WINDOWS + 1);
    localparam int RTRY_W = $clog2(RETRY_WINDOWS + 1);
    // Tolerance band evaluated in a wide signed domain so the lower bound can clamp at 0
    localparam logic signed [63:0] LO_BOUND = (EXP_CNT > TOL) ? 64'(EXP_CNT - TOL) : 64'sd0;
    localparam logic signed [63:0] HI_BOUND = 64'(EXP_CNT) + 64'(TOL);

    typedef enum logic [1:0] {ST_PD, ST_WAIT_CLK, ST_LOCKED} state_t;

    logic [WIN_W-1:0]      r_win_cnt;
    logic                  w_tick;
    logic [NUM_REFCLK-1:0] r_sync1;
    logic [NUM_REFCLK-1:0] r_sync2;
    logic [NUM_REFCLK-1:0] r_sync3;
    logic [NUM_REFCLK-1:0] w_edge;

    assign w_tick = (r_win_cnt == WIN_W'(WINDOW_CYCLES - 1));
    assign w_edge = r_sync2 ^ r_sync3;

    // Shared measurement window timer, wraps after WINDOW_CYCLES cycles
    always_ff @(posedge i_free_clk or posedge i_rst) begin
        if (i_rst)       r_win_cnt <= '0;
        else if (w_tick) r_win_cnt <= '0;
        else             r_win_cnt <= r_win_cnt + 1'b1;
    end

    // Three-flop synchroniser for the asynchronous refclk toggles
    always_ff @(posedge i_free_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sync3 <= '0;
        end else begin
            r_sync1 <= i_refclk_tgl;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    genvar k;
    generate
        for (k = 0; k < NUM_REFCLK; k++) begin : g_ch
            logic [CNT_W-1:0]   r_edge_cnt;
            logic [CNT_W-1:0]   r_freq;
            logic [CNT_W-1:0]   w_cnt_inc;
            logic signed [63:0] w_cnt_ext;
            logic               w_good;
            state_t             r_state;
            logic [HOLD_W-1:0]  r_hold;
            logic [GOOD_W-1:0]  r_good;
            logic [RTRY_W-1:0]  r_wins;
            logic               r_discard;
            logic               r_pd;
            logic               r_ok;
            logic               r_lost;
            logic [3:0]         r_retry;

            // Count including this cycle's edge, saturating at all ones
            assign w_cnt_inc = (&r_edge_cnt) ? r_edge_cnt : r_edge_cnt + CNT_W'(w_edge[k]);
            assign w_cnt_ext = $signed(64'(w_cnt_inc));
            assign w_good    = (w_cnt_ext >= LO_BOUND) && (w_cnt_ext <= HI_BOUND);

            assign o_com_powerdown[k]          = r_pd;
            assign o_refclk_ok[k]              = r_ok;
            assign o_refclk_lost[k]            = r_lost;
            assign o_freq_cnt[k*CNT_W +: CNT_W] = r_freq;
            assign o_retry_cnt[k*4 +: 4]       = r_retry;

            // Edge accumulation; the completed window count is latched on each tick
            always_ff @(posedge i_free_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_edge_cnt <= '0;
                    r_freq     <= '0;
                end else if (w_tick) begin
                    r_freq     <= w_cnt_inc;
                    r_edge_cnt <= '0;
                end else begin
                    r_edge_cnt <= w_cnt_inc;
                end
            end

            // Power-down / lock supervisor with registered outputs; i_pd_req overrides everything
            always_ff @(posedge i_free_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_state   <= ST_PD;
                    r_hold    <= '0;
                    r_good    <= '0;
                    r_wins    <= '0;
                    r_discard <= 1'b1;
                    r_pd      <= 1'b1;
                    r_ok      <= 1'b0;
                    r_lost    <= 1'b0;
                    r_retry   <= 4'd0;
                end else begin
                    r_lost <= 1'b0;
                    if (i_pd_req[k]) begin
                        r_state <= ST_PD;
                        r_hold  <= '0;
                        r_pd    <= 1'b1;
                        r_ok    <= 1'b0;
                    end else begin
                        case (r_state)
                            ST_PD: begin
                                r_pd <= 1'b1;
                                if (r_hold == HOLD_W'(PD_HOLD_CYCLES - 1)) begin
                                    r_state   <= ST_WAIT_CLK;
                                    r_pd      <= 1'b0;
                                    r_hold    <= '0;
                                    r_discard <= 1'b1;
                                    r_good    <= '0;
                                    r_wins    <= '0;
                                end else begin
                                    r_hold <= r_hold + 1'b1;
                                end
                            end
                            ST_WAIT_CLK: begin
                                if (w_tick) begin
                                    if (r_discard) begin
                                        // First window after entry is only partially observed
                                        r_discard <= 1'b0;
                                    end else if (w_good && (r_good == GOOD_W'(GOOD_WINDOWS - 1))) begin
                                        r_state <= ST_LOCKED;
                                        r_ok    <= 1'b1;
                                        r_good  <= '0;
                                        r_wins  <= '0;
                                    end else if (r_wins == RTRY_W'(RETRY_WINDOWS - 1)) begin
                                        r_state <= ST_PD;
                                        r_pd    <= 1'b1;
                                        r_hold  <= '0;
                                        if (r_retry != 4'hF) r_retry <= r_retry + 4'd1;
                                    end else begin
                                        r_wins <= r_wins + 1'b1;
                                        r_good <= w_good ? r_good + 1'b1 : '0;
                                    end
                                end
                            end
                            ST_LOCKED: begin
                                if (w_tick && !w_good) begin
                                    r_state   <= ST_WAIT_CLK;
                                    r_ok      <= 1'b0;
                                    r_lost    <= 1'b1;
                                    r_discard <= 1'b1;
                                    r_good    <= '0;
                                    r_wins    <= '0;
                                end
                            end
                            default: begin
                                r_state <= ST_PD;
                                r_pd    <= 1'b1;
                                r_ok    <= 1'b0;
                                r_hold  <= '0;
                            end
                        endcase
                    end
                end
            end
        end
    endgenerate
endmodule
